alu_ctrl_seq: RTL and testbench



---
 rtl/alu_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered MIPS execute-stage ALU control decoder with a mult/div
// iteration sequencer and a hi/lo interlock driven by a valid/ready handshake.
module alu_ctrl_seq #(
    parameter int CTRL_W     = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    output logic              ctrl_valid,
    output logic [CTRL_W-1:0] ALUctrl,
    output logic [1:0]        hilo_rd,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_busy,
    output logic              md_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             md_start_reg, md_start_next;
    logic [1:0]       md_op_reg, md_op_next;
    logic             ctrl_valid_reg;
    logic [2:0]       ctrl_reg;
    logic [1:0]       hilo_reg;
    logic             illegal_reg;

    logic [2:0]       dec_ctrl;
    logic [1:0]       dec_hilo;
    logic             dec_illegal;
    logic             dec_md;
    logic             accept;

    always_comb begin
        dec_ctrl    = 3'b000;
        dec_hilo    = 2'b00;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        case (ALUOp)
            2'b00: dec_ctrl = 3'b010;
            2'b01: dec_ctrl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: dec_ctrl = 3'b010;
                    6'b100010, 6'b100011: dec_ctrl = 3'b110;
                    6'b100100:            dec_ctrl = 3'b000;
                    6'b100101:            dec_ctrl = 3'b001;
                    6'b100110:            dec_ctrl = 3'b011;
                    6'b100111:            dec_ctrl = 3'b100;
                    6'b101010:            dec_ctrl = 3'b111;
                    6'b101011:            dec_ctrl = 3'b101;
                    6'b010000:            dec_hilo = 2'b01;
                    6'b010010:            dec_hilo = 2'b10;
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: dec_md   = 1'b1;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Only requests touching hi/lo or the mult/div unit wait; plain ALU ops overlap.
    assign in_ready = !((state_reg == RUN) && (dec_md || (dec_hilo != 2'b00)));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        md_start_next = 1'b0;
        md_op_next    = md_op_reg;
        case (state_reg)
            IDLE: begin
                if (accept && dec_md) begin
                    state_next    = RUN;
                    md_start_next = 1'b1;
                    md_op_next    = funct[1:0];
                    cnt_next      = funct[1] ? CNT_W'(DIV_CYCLES - 1)
                                             : CNT_W'(MUL_CYCLES - 1);
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            md_start_reg   <= 1'b0;
            md_op_reg      <= 2'b00;
            ctrl_valid_reg <= 1'b0;
            ctrl_reg       <= 3'b000;
            hilo_reg       <= 2'b00;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            md_start_reg   <= md_start_next;
            md_op_reg      <= md_op_next;
            ctrl_valid_reg <= accept;
            if (accept) begin
                ctrl_reg    <= dec_ctrl;
                hilo_reg    <= dec_hilo;
                illegal_reg <= dec_illegal;
            end
        end
    end

    assign ctrl_valid   = ctrl_valid_reg;
    assign ALUctrl[2:0] = ctrl_reg;
    assign hilo_rd      = hilo_reg;
    assign illegal      = illegal_reg;
    assign md_start     = md_start_reg;
    assign md_op        = md_op_reg;
    assign md_busy      = (state_reg == RUN);
    assign md_done      = (state_reg == RUN) && (cnt_reg == '0);

    // Wider control codes carry the base 3-bit code with zero upper bits.
    genvar gi;
    generate
        for (gi = 3; gi < CTRL_W; gi = gi + 1) begin : g_zext
            assign ALUctrl[gi] = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: a default instance and a CTRL_W=5,
// MUL_CYCLES=1 instance, each with its own expected-result queue.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_valid5 = 1'b0;
    logic [1:0] ALUOp = 2'b00, ALUOp5 = 2'b00;
    logic [5:0] funct = 6'b0, funct5 = 6'b0;

    logic       in_ready, ctrl_valid, illegal, md_start, md_busy, md_done;
    logic [2:0] ALUctrl;
    logic [1:0] hilo_rd, md_op;
    logic       in_ready5, ctrl_valid5, illegal5, md_start5, md_busy5, md_done5;
    logic [4:0] ALUctrl5;
    logic [1:0] hilo_rd5, md_op5;

    int n_checks = 0;
    int n_fail   = 0;
    int done0    = 0;
    int done5    = 0;
    logic [7:0] q0[$];
    logic [7:0] q5[$];
    logic [7:0] last0 = '0;
    logic [7:0] last5 = '0;
    logic [5:0] ftab [0:11] = '{6'b100000, 6'b100011, 6'b100100, 6'b100110,
                                6'b100111, 6'b101010, 6'b010000, 6'b010010,
                                6'b011001, 6'b011010, 6'b111111, 6'b000000};

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct(funct), .ctrl_valid(ctrl_valid), .ALUctrl(ALUctrl),
        .hilo_rd(hilo_rd), .illegal(illegal), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .md_done(md_done)
    );

    alu_ctrl_seq #(.CTRL_W(5), .MUL_CYCLES(1)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .ALUOp(ALUOp5), .funct(funct5), .ctrl_valid(ctrl_valid5), .ALUctrl(ALUctrl5),
        .hilo_rd(hilo_rd5), .illegal(illegal5), .md_start(md_start5), .md_op(md_op5),
        .md_busy(md_busy5), .md_done(md_done5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected {illegal, hilo_rd[1:0], ctrl[4:0]} for a request.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [5:0] f);
        logic [4:0] c;
        logic [1:0] h;
        logic       ill;
        c = 5'b0; h = 2'b0; ill = 1'b0;
        if (op == 2'b00) c = 5'b00010;
        else if (op == 2'b01) c = 5'b00110;
        else if (op == 2'b11) ill = 1'b1;
        else begin
            case (f)
                6'b100000, 6'b100001: c = 5'b00010;
                6'b100010, 6'b100011: c = 5'b00110;
                6'b100100: c = 5'b00000;
                6'b100101: c = 5'b00001;
                6'b100110: c = 5'b00011;
                6'b100111: c = 5'b00100;
                6'b101010: c = 5'b00111;
                6'b101011: c = 5'b00101;
                6'b010000: h = 2'b01;
                6'b010010: h = 2'b10;
                6'b011000, 6'b011001, 6'b011010, 6'b011011: c = 5'b0;
                default: ill = 1'b1;
            endcase
        end
        return {ill, h, c};
    endfunction

    // Reset discards anything in flight.
    always @(posedge clk) begin
        if (rst) begin
            q0.delete(); q5.delete();
            last0 = '0; last5 = '0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (md_done === 1'b1) done0++;
        if (ctrl_valid === 1'b1) begin
            if (q0.size() == 0) check("dut_ctrl_valid_extra", ctrl_valid, 0);
            else begin
                e = q0.pop_front();
                last0 = e;
                $display("dut  txn ALUctrl=%b hilo_rd=%b illegal=%b", ALUctrl, hilo_rd, illegal);
                check("dut_ALUctrl", ALUctrl, e[2:0]);
                check("dut_hilo_rd", hilo_rd, e[6:5]);
                check("dut_illegal", illegal, e[7]);
            end
        end else begin
            if (q0.size() != 0) begin
                check("dut_ctrl_valid_missing", ctrl_valid, 1);
                void'(q0.pop_front());
            end
            check("dut_hold", {illegal, hilo_rd, ALUctrl}, {last0[7:5], last0[2:0]});
        end
        if (!rst && in_valid && in_ready) q0.push_back(model(ALUOp, funct));
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (md_done5 === 1'b1) done5++;
        if (ctrl_valid5 === 1'b1) begin
            if (q5.size() == 0) check("dut5_ctrl_valid_extra", ctrl_valid5, 0);
            else begin
                e = q5.pop_front();
                last5 = e;
                $display("dut5 txn ALUctrl=%b hilo_rd=%b illegal=%b", ALUctrl5, hilo_rd5, illegal5);
                check("dut5_ALUctrl", ALUctrl5, e[4:0]);
                check("dut5_hilo_rd", hilo_rd5, e[6:5]);
                check("dut5_illegal", illegal5, e[7]);
            end
        end else begin
            if (q5.size() != 0) begin
                check("dut5_ctrl_valid_missing", ctrl_valid5, 1);
                void'(q5.pop_front());
            end
            check("dut5_hold", {illegal5, hilo_rd5, ALUctrl5}, last5);
        end
        if (!rst && in_valid5 && in_ready5) q5.push_back(model(ALUOp5, funct5));
    end

    // Present a request and hold it until accepted; returns the stall count.
    task automatic send(input bit sel, input logic [1:0] op, input logic [5:0] f, output int waits);
        if (sel) begin ALUOp5 = op; funct5 = f; in_valid5 = 1'b1; end
        else     begin ALUOp  = op; funct  = f; in_valid  = 1'b1; end
        waits = 0;
        while (1) begin
            @(negedge clk);
            if ((sel ? in_ready5 : in_ready) === 1'b1) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", waits, 0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid5 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, d0;
        logic [1:0] sops [0:5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0] sfns [0:5] = '{6'b0, 6'b0, 6'b100100, 6'b100101, 6'b101010, 6'b101011};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_ctrl_valid", ctrl_valid, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_md_op", md_op, 0);
        check("rst_md_start", md_start, 0);
        @(posedge clk); #1;

        // Back-to-back ALU requests
        for (int i = 0; i < 6; i++) begin
            send(0, sops[i], sfns[i], w);
            check("seq_wait", w, 0);
        end

        // mult timing
        send(0, 2'b10, 6'b011000, w);
        check("mult_wait", w, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("mult_start", md_start, (k == 1));
            check("mult_busy", md_busy, (k <= 4));
            check("mult_done", md_done, (k == 4));
            if (k <= 4) check("mult_op", md_op, 2'b00);
            @(posedge clk); #1;
        end

        // div with overlapping add and an interlocked mflo
        d0 = done0;
        send(0, 2'b10, 6'b011010, w);
        @(negedge clk);
        check("div_start", md_start, 1);
        check("div_op", md_op, 2'b10);
        @(posedge clk); #1;
        send(0, 2'b00, 6'b000000, w);
        check("add_overlap_wait", w, 0);
        ALUOp = 2'b10; funct = 6'b010010;
        @(negedge clk);
        check("mflo_ready_no_valid", in_ready, 0);
        @(posedge clk); #1;
        send(0, 2'b10, 6'b010010, w);
        check("mflo_wait", w, 29);
        check("div_done_count", done0 - d0, 1);

        // Illegal requests
        send(0, 2'b10, 6'b111111, w);
        check("ill_funct_wait", w, 0);
        @(negedge clk);
        check("ill_funct_busy", md_busy, 0);
        check("ill_funct_ready", in_ready, 1);
        @(posedge clk); #1;
        send(0, 2'b11, 6'b011000, w);
        check("ill_op_wait", w, 0);
        @(negedge clk);
        check("ill_op_busy", md_busy, 0);
        check("ill_op_start", md_start, 0);
        check("ill_op_ready", in_ready, 1);
        @(posedge clk); #1;

        // CTRL_W=5, MUL_CYCLES=1 instance
        send(1, 2'b10, 6'b100101, w);
        send(1, 2'b10, 6'b011000, w);
        ALUOp5 = 2'b10; funct5 = 6'b010000;
        @(negedge clk);
        check("m1_start", md_start5, 1);
        check("m1_done", md_done5, 1);
        check("m1_busy", md_busy5, 1);
        check("m1_mfhi_blocked", in_ready5, 0);
        @(posedge clk); #1;
        send(1, 2'b10, 6'b010000, w);
        check("m1_mfhi_wait", w, 0);

        // Reset in the middle of a div
        send(0, 2'b10, 6'b011011, w);
        send(0, 2'b01, 6'b000000, w);
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        check("pre_rst_busy", md_busy, 1);
        d0 = done0;
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", md_busy, 0);
        check("post_rst_done", md_done, 0);
        check("post_rst_start", md_start, 0);
        check("post_rst_op", md_op, 0);
        check("post_rst_ctrl_valid", ctrl_valid, 0);
        check("post_rst_outs", {illegal, hilo_rd, ALUctrl}, 0);
        check("post_rst_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_no_done", done0 - d0, 0);

        // Random mix
        for (int i = 0; i < 30; i++) begin
            send(0, 2'($urandom_range(0, 3)), ftab[$urandom_range(0, 11)], w);
        end

        for (int i = 0; i < 60 && md_busy; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_busy", md_busy, 0);
        check("q0_empty", q0.size(), 0);
        check("q5_empty", q5.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
